// File: rtl/arc4_core_param.sv
// ARC4 decryption core with configurable key length and optional
// printable-ASCII early abort. Reads a length-prefixed ciphertext from an
// external registered RAM and writes a length-prefixed plaintext.
module arc4_core_param #(
    parameter int unsigned KEY_BYTES       = 3,
    parameter int unsigned CHECK_PRINTABLE = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic                   rdy,
    input  logic [8*KEY_BYTES-1:0] key,
    output logic [7:0]             ct_addr,
    input  logic [7:0]             ct_rddata,
    output logic [7:0]             pt_addr,
    output logic [7:0]             pt_wrdata,
    output logic                   pt_wren,
    output logic                   done,
    output logic                   key_ok
);

    localparam int unsigned KW = 8 * KEY_BYTES;
    localparam int unsigned PW = 3;
    localparam int unsigned IW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_KSA,
        S_LEN,
        S_PRGA,
        S_FIN,
        S_ABORT
    } state_t;

    state_t          r_state, w_state_n;
    logic [PW-1:0]   r_ph, w_ph_n;
    logic [7:0]      r_i, w_i_n;
    logic [7:0]      r_j, w_j_n;
    logic [7:0]      r_si, w_si_n;
    logic [7:0]      r_sj, w_sj_n;
    logic [7:0]      r_k, w_k_n;
    logic [7:0]      r_len, w_len_n;
    logic [IW-1:0]   r_kidx, w_kidx_n;
    logic [KW-1:0]   r_key, w_key_n;
    logic            r_rdy, w_rdy_n;
    logic            r_done, w_done_n;
    logic            r_key_ok, w_key_ok_n;
    logic [7:0]      r_ct_addr, w_ct_addr_n;
    logic [7:0]      r_pt_addr, w_pt_addr_n;
    logic [7:0]      r_pt_wrdata, w_pt_wrdata_n;
    logic            r_pt_wren, w_pt_wren_n;

    logic [7:0]      r_sbox [256];
    logic [7:0]      r_s_rdata;
    logic            w_s_we;
    logic [7:0]      w_s_waddr;
    logic [7:0]      w_s_wdata;
    logic [7:0]      w_s_raddr;

    logic [7:0]      w_kbyte;
    logic [7:0]      w_i_inc;
    logic [7:0]      w_j_ksa;
    logic [7:0]      w_j_prga;
    logic [7:0]      w_pad_idx;
    logic [7:0]      w_pt_byte;
    logic            w_bad;

    assign w_i_inc   = r_i + 8'd1;
    assign w_j_ksa   = r_j + r_s_rdata + w_kbyte;
    assign w_j_prga  = r_j + r_s_rdata;
    assign w_pad_idx = r_si + r_sj;
    assign w_pt_byte = r_s_rdata ^ ct_rddata;
    assign w_bad     = (CHECK_PRINTABLE != 0) &&
                       ((w_pt_byte < 8'h20) || (w_pt_byte > 8'h7E));

    // Key byte selection, MSB-first: index 0 is the most significant byte
    always_comb begin
        w_kbyte = 8'h00;
        for (int k = 0; k < int'(KEY_BYTES); k++) begin
            if (r_kidx == IW'(k)) begin
                w_kbyte = r_key[8*(int'(KEY_BYTES)-k)-1 -: 8];
            end
        end
    end

    // S-box: one synchronous read port, one write port; read returns pre-write data
    always_ff @(posedge clk) begin
        if (w_s_we) begin
            r_sbox[w_s_waddr] <= w_s_wdata;
        end
        r_s_rdata <= r_sbox[w_s_raddr];
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ph        <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_si        <= '0;
            r_sj        <= '0;
            r_k         <= '0;
            r_len       <= '0;
            r_kidx      <= '0;
            r_key       <= '0;
            r_rdy       <= 1'b0;
            r_done      <= 1'b0;
            r_key_ok    <= 1'b0;
            r_ct_addr   <= '0;
            r_pt_addr   <= '0;
            r_pt_wrdata <= '0;
            r_pt_wren   <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_ph        <= w_ph_n;
            r_i         <= w_i_n;
            r_j         <= w_j_n;
            r_si        <= w_si_n;
            r_sj        <= w_sj_n;
            r_k         <= w_k_n;
            r_len       <= w_len_n;
            r_kidx      <= w_kidx_n;
            r_key       <= w_key_n;
            r_rdy       <= w_rdy_n;
            r_done      <= w_done_n;
            r_key_ok    <= w_key_ok_n;
            r_ct_addr   <= w_ct_addr_n;
            r_pt_addr   <= w_pt_addr_n;
            r_pt_wrdata <= w_pt_wrdata_n;
            r_pt_wren   <= w_pt_wren_n;
        end
    end

    // Next-state, datapath and S-box port control; KSA/PRGA are phased so every
    // S-box read happens after the preceding write has landed
    always_comb begin
        w_state_n     = r_state;
        w_ph_n        = r_ph;
        w_i_n         = r_i;
        w_j_n         = r_j;
        w_si_n        = r_si;
        w_sj_n        = r_sj;
        w_k_n         = r_k;
        w_len_n       = r_len;
        w_kidx_n      = r_kidx;
        w_key_n       = r_key;
        w_rdy_n       = r_rdy;
        w_done_n      = 1'b0;
        w_key_ok_n    = r_key_ok;
        w_ct_addr_n   = r_ct_addr;
        w_pt_addr_n   = r_pt_addr;
        w_pt_wrdata_n = r_pt_wrdata;
        w_pt_wren_n   = 1'b0;
        w_s_we        = 1'b0;
        w_s_waddr     = r_i;
        w_s_wdata     = r_i;
        w_s_raddr     = r_i;

        case (r_state)
            S_IDLE: begin
                if (r_rdy && en) begin
                    w_key_n    = key;
                    w_rdy_n    = 1'b0;
                    w_key_ok_n = 1'b0;
                    w_i_n      = '0;
                    w_state_n  = S_INIT;
                end else begin
                    w_rdy_n = 1'b1;
                end
            end

            S_INIT: begin
                w_s_we    = 1'b1;
                w_s_waddr = r_i;
                w_s_wdata = r_i;
                w_i_n     = w_i_inc;
                if (r_i == 8'hFF) begin
                    w_state_n = S_KSA;
                    w_ph_n    = '0;
                    w_j_n     = '0;
                    w_kidx_n  = '0;
                end
            end

            S_KSA: begin
                case (r_ph)
                    PW'(0): begin
                        w_s_raddr = r_i;
                        w_ph_n    = PW'(1);
                    end
                    PW'(1): begin
                        w_si_n    = r_s_rdata;
                        w_j_n     = w_j_ksa;
                        w_s_raddr = w_j_ksa;
                        w_ph_n    = PW'(2);
                    end
                    PW'(2): begin
                        w_s_we    = 1'b1;
                        w_s_waddr = r_i;
                        w_s_wdata = r_s_rdata;
                        w_ph_n    = PW'(3);
                    end
                    PW'(3): begin
                        w_s_we    = 1'b1;
                        w_s_waddr = r_j;
                        w_s_wdata = r_si;
                        w_i_n     = w_i_inc;
                        w_kidx_n  = (r_kidx == IW'(KEY_BYTES - 1)) ? '0 : r_kidx + IW'(1);
                        w_ph_n    = '0;
                        if (r_i == 8'hFF) begin
                            w_state_n   = S_LEN;
                            w_ct_addr_n = '0;
                        end
                    end
                    default: w_ph_n = '0;
                endcase
            end

            S_LEN: begin
                case (r_ph)
                    PW'(0): w_ph_n = PW'(1);
                    PW'(1): begin
                        w_len_n       = ct_rddata;
                        w_pt_addr_n   = '0;
                        w_pt_wrdata_n = ct_rddata;
                        w_pt_wren_n   = 1'b1;
                        w_ph_n        = PW'(2);
                    end
                    default: begin
                        w_i_n     = '0;
                        w_j_n     = '0;
                        w_k_n     = 8'd1;
                        w_ph_n    = '0;
                        w_state_n = (r_len == 8'd0) ? S_FIN : S_PRGA;
                    end
                endcase
            end

            S_PRGA: begin
                case (r_ph)
                    PW'(0): begin
                        w_i_n       = w_i_inc;
                        w_s_raddr   = w_i_inc;
                        w_ct_addr_n = r_k;
                        w_ph_n      = PW'(1);
                    end
                    PW'(1): begin
                        w_si_n    = r_s_rdata;
                        w_j_n     = w_j_prga;
                        w_s_raddr = w_j_prga;
                        w_ph_n    = PW'(2);
                    end
                    PW'(2): begin
                        w_sj_n    = r_s_rdata;
                        w_s_we    = 1'b1;
                        w_s_waddr = r_i;
                        w_s_wdata = r_s_rdata;
                        w_ph_n    = PW'(3);
                    end
                    PW'(3): begin
                        w_s_we    = 1'b1;
                        w_s_waddr = r_j;
                        w_s_wdata = r_si;
                        w_ph_n    = PW'(4);
                    end
                    PW'(4): begin
                        w_s_raddr = w_pad_idx;
                        w_ph_n    = PW'(5);
                    end
                    PW'(5): begin
                        if (w_bad) begin
                            w_state_n = S_ABORT;
                            w_ph_n    = '0;
                        end else begin
                            w_pt_addr_n   = r_k;
                            w_pt_wrdata_n = w_pt_byte;
                            w_pt_wren_n   = 1'b1;
                            if (r_k == r_len) begin
                                w_ph_n = PW'(6);
                            end else begin
                                w_k_n  = r_k + 8'd1;
                                w_ph_n = '0;
                            end
                        end
                    end
                    default: begin
                        w_state_n = S_FIN;
                        w_ph_n    = '0;
                    end
                endcase
            end

            S_FIN: begin
                w_done_n   = 1'b1;
                w_key_ok_n = 1'b1;
                w_rdy_n    = 1'b1;
                w_state_n  = S_IDLE;
            end

            S_ABORT: begin
                w_done_n   = 1'b1;
                w_key_ok_n = 1'b0;
                w_rdy_n    = 1'b1;
                w_state_n  = S_IDLE;
            end

            default: w_state_n = S_IDLE;
        endcase
    end

    assign rdy       = r_rdy;
    assign done      = r_done;
    assign key_ok    = r_key_ok;
    assign ct_addr   = r_ct_addr;
    assign pt_addr   = r_pt_addr;
    assign pt_wrdata = r_pt_wrdata;
    assign pt_wren   = r_pt_wren;

endmodule

// File: tb/tb_arc4_core_param.sv
// Directed bench for arc4_core_param: three instances (3-byte key, 5-byte key,
// 3-byte key with printable abort) share one ciphertext RAM and one pt RAM.
module tb_arc4_core_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        en_a = 1'b0, en_b = 1'b0, en_c = 1'b0;
    logic [23:0] key_a = '0, key_c = '0;
    logic [39:0] key_b = '0;

    logic       rdy_a, done_a, key_ok_a, pt_wren_a;
    logic [7:0] ct_addr_a, pt_addr_a, pt_wrdata_a, ct_rd_a;
    logic       rdy_b, done_b, key_ok_b, pt_wren_b;
    logic [7:0] ct_addr_b, pt_addr_b, pt_wrdata_b, ct_rd_b;
    logic       rdy_c, done_c, key_ok_c, pt_wren_c;
    logic [7:0] ct_addr_c, pt_addr_c, pt_wrdata_c, ct_rd_c;

    logic [7:0] ct_mem [256];
    logic [7:0] pt_mem [256];
    int         pt_tag [256];
    int         run_id = 0;
    int         wr_cnt = 0;
    logic [7:0] ks [256];
    int         total = 0;
    int         bad = 0;

    logic [7:0] t2_ct [13] = '{8'd12, 8'h3a, 8'hc5, 8'h10, 8'h9f, 8'h00, 8'hff,
                              8'h47, 8'h81, 8'h2e, 8'h6b, 8'hd4, 8'h55};
    logic [7:0] rfc5 [5] = '{8'hb2, 8'h39, 8'h63, 8'h05, 8'hf0};

    arc4_core_param #(.KEY_BYTES(3), .CHECK_PRINTABLE(0)) u_dut_a (
        .clk(clk), .rst(rst), .en(en_a), .rdy(rdy_a), .key(key_a),
        .ct_addr(ct_addr_a), .ct_rddata(ct_rd_a), .pt_addr(pt_addr_a),
        .pt_wrdata(pt_wrdata_a), .pt_wren(pt_wren_a), .done(done_a), .key_ok(key_ok_a));

    arc4_core_param #(.KEY_BYTES(5), .CHECK_PRINTABLE(0)) u_dut_b (
        .clk(clk), .rst(rst), .en(en_b), .rdy(rdy_b), .key(key_b),
        .ct_addr(ct_addr_b), .ct_rddata(ct_rd_b), .pt_addr(pt_addr_b),
        .pt_wrdata(pt_wrdata_b), .pt_wren(pt_wren_b), .done(done_b), .key_ok(key_ok_b));

    arc4_core_param #(.KEY_BYTES(3), .CHECK_PRINTABLE(1)) u_dut_c (
        .clk(clk), .rst(rst), .en(en_c), .rdy(rdy_c), .key(key_c),
        .ct_addr(ct_addr_c), .ct_rddata(ct_rd_c), .pt_addr(pt_addr_c),
        .pt_wrdata(pt_wrdata_c), .pt_wren(pt_wren_c), .done(done_c), .key_ok(key_ok_c));

    // Registered ciphertext RAM read ports
    always @(posedge clk) begin
        ct_rd_a <= ct_mem[ct_addr_a];
        ct_rd_b <= ct_mem[ct_addr_b];
        ct_rd_c <= ct_mem[ct_addr_c];
    end

    // Plaintext RAM: records data, the run that wrote it, and a write count
    always @(posedge clk) begin
        if (pt_wren_a) begin
            pt_mem[pt_addr_a] <= pt_wrdata_a;
            pt_tag[pt_addr_a] <= run_id;
            wr_cnt <= wr_cnt + 1;
        end else if (pt_wren_b) begin
            pt_mem[pt_addr_b] <= pt_wrdata_b;
            pt_tag[pt_addr_b] <= run_id;
            wr_cnt <= wr_cnt + 1;
        end else if (pt_wren_c) begin
            pt_mem[pt_addr_c] <= pt_wrdata_c;
            pt_tag[pt_addr_c] <= run_id;
            wr_cnt <= wr_cnt + 1;
        end
    end

    // Software RC4 keystream: ks[n] is the n-th output byte (n = 1..255)
    task automatic model_ks(input logic [127:0] k, input int nb);
        logic [7:0] s [256];
        logic [7:0] j, t, i8, idx;
        for (int i = 0; i < 256; i++) s[i] = 8'(i);
        j = 8'h00;
        for (int i = 0; i < 256; i++) begin
            j = j + s[i] + k[8*(nb-(i%nb))-1 -: 8];
            t = s[i]; s[i] = s[j]; s[j] = t;
        end
        i8 = 8'h00;
        j  = 8'h00;
        ks[0] = 8'h00;
        for (int n = 1; n < 256; n++) begin
            i8 = i8 + 8'd1;
            j  = j + s[i8];
            t = s[i8]; s[i8] = s[j]; s[j] = t;
            idx = s[i8] + s[j];
            ks[n] = s[idx];
        end
    endtask

    function automatic logic sel_done(input int w);
        case (w)
            0: return done_a;
            1: return done_b;
            default: return done_c;
        endcase
    endfunction

    function automatic logic sel_kok(input int w);
        case (w)
            0: return key_ok_a;
            1: return key_ok_b;
            default: return key_ok_c;
        endcase
    endfunction

    function automatic logic sel_rdy(input int w);
        case (w)
            0: return rdy_a;
            1: return rdy_b;
            default: return rdy_c;
        endcase
    endfunction

    task automatic pulse_en(input int w);
        @(negedge clk);
        if (w == 0) en_a = 1'b1; else if (w == 1) en_b = 1'b1; else en_c = 1'b1;
        @(negedge clk);
        en_a = 1'b0; en_b = 1'b0; en_c = 1'b0;
    endtask

    // Bounded wait for the done pulse; returns key_ok and rdy seen in that cycle
    task automatic wait_done(input int w, input int budget, output logic kok, output logic rdys);
        bit seen = 1'b0;
        kok  = 1'b0;
        rdys = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (sel_done(w) === 1'b1) begin
                seen = 1'b1;
                kok  = sel_kok(w);
                rdys = sel_rdy(w);
                break;
            end
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL done_timeout dut=%0d got=no_done exp=done within %0d cycles", w, budget);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++;
        if ({rdy_a, done_a, key_ok_a, pt_wren_a, ct_addr_a, pt_addr_a, pt_wrdata_a} !== 28'h0) begin
            bad++;
            $display("FAIL reset_outputs got=%h exp=0",
                     {rdy_a, done_a, key_ok_a, pt_wren_a, ct_addr_a, pt_addr_a, pt_wrdata_a});
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({rdy_a, rdy_b, rdy_c} !== 3'b111) begin
            bad++;
            $display("FAIL reset_rdy_rise got=%b exp=111", {rdy_a, rdy_b, rdy_c});
        end
    endtask

    task automatic test_basic;
        logic kok, rdys;
        int w0;
        for (int n = 0; n < 13; n++) ct_mem[n] = t2_ct[n];
        model_ks({104'h0, 24'h000018}, 3);
        run_id++;
        w0 = wr_cnt;
        key_a = 24'h000018;
        pulse_en(0);
        key_a = 24'hffffff;
        wait_done(0, 4000, kok, rdys);
        total++;
        if (kok !== 1'b1 || rdys !== 1'b1) begin
            bad++;
            $display("FAIL basic_keyok_rdy got=%b%b exp=11", kok, rdys);
        end
        total++;
        if (wr_cnt - w0 != 13) begin
            bad++;
            $display("FAIL basic_wr_count got=%0d exp=13", wr_cnt - w0);
        end
        for (int n = 0; n < 13; n++) begin
            logic [7:0] e;
            e = (n == 0) ? 8'd12 : (ks[n] ^ t2_ct[n]);
            total++;
            if (pt_tag[n] != run_id || pt_mem[n] !== e) begin
                bad++;
                $display("FAIL basic_pt[%0d] got=%h exp=%h", n, pt_mem[n], e);
            end
        end
        total++;
        if (pt_tag[13] == run_id) begin
            bad++;
            $display("FAIL basic_no_write_13 got=written exp=untouched");
        end
    endtask

    task automatic test_key5;
        logic kok, rdys;
        ct_mem[0] = 8'd5;
        for (int n = 1; n <= 5; n++) ct_mem[n] = 8'h00;
        run_id++;
        key_b = 40'h0102030405;
        pulse_en(1);
        wait_done(1, 4000, kok, rdys);
        total++;
        if (kok !== 1'b1) begin
            bad++;
            $display("FAIL key5_key_ok got=%b exp=1", kok);
        end
        total++;
        if (pt_tag[0] != run_id || pt_mem[0] !== 8'd5) begin
            bad++;
            $display("FAIL key5_len got=%h exp=05", pt_mem[0]);
        end
        for (int n = 1; n <= 5; n++) begin
            total++;
            if (pt_tag[n] != run_id || pt_mem[n] !== rfc5[n-1]) begin
                bad++;
                $display("FAIL key5_pt[%0d] got=%h exp=%h", n, pt_mem[n], rfc5[n-1]);
            end
        end
    endtask

    task automatic test_printable_abort;
        logic kok, rdys;
        int w0;
        model_ks({104'h0, 24'h000018}, 3);
        ct_mem[0] = 8'd4;
        ct_mem[1] = ks[1] ^ 8'h48;
        ct_mem[2] = ks[2] ^ 8'h69;
        ct_mem[3] = ks[3] ^ 8'h07;
        ct_mem[4] = ks[4] ^ 8'h78;
        run_id++;
        w0 = wr_cnt;
        key_c = 24'h000018;
        pulse_en(2);
        wait_done(2, 4000, kok, rdys);
        total++;
        if (kok !== 1'b0 || rdys !== 1'b1) begin
            bad++;
            $display("FAIL abort_keyok_rdy got=%b%b exp=01", kok, rdys);
        end
        total++;
        if (pt_tag[1] != run_id || pt_mem[1] !== 8'h48 || pt_tag[2] != run_id || pt_mem[2] !== 8'h69) begin
            bad++;
            $display("FAIL abort_prefix got=%h%h exp=4869", pt_mem[1], pt_mem[2]);
        end
        total++;
        if (pt_tag[3] == run_id || pt_tag[4] == run_id) begin
            bad++;
            $display("FAIL abort_no_write got=written exp=untouched");
        end
        total++;
        if (wr_cnt - w0 != 3) begin
            bad++;
            $display("FAIL abort_wr_count got=%0d exp=3", wr_cnt - w0);
        end
    endtask

    task automatic test_len_zero;
        logic kok, rdys;
        int w0;
        ct_mem[0] = 8'd0;
        ct_mem[1] = 8'h5a;
        run_id++;
        w0 = wr_cnt;
        key_a = 24'h123456;
        pulse_en(0);
        wait_done(0, 4000, kok, rdys);
        total++;
        if (kok !== 1'b1 || wr_cnt - w0 != 1) begin
            bad++;
            $display("FAIL len0_result got=kok%b/wr%0d exp=kok1/wr1", kok, wr_cnt - w0);
        end
        total++;
        if (pt_tag[0] != run_id || pt_mem[0] !== 8'h00 || pt_tag[1] == run_id) begin
            bad++;
            $display("FAIL len0_pt got=%h exp=00 only", pt_mem[0]);
        end
    endtask

    task automatic test_en_mid_ksa;
        logic kok, rdys;
        int dcnt;
        for (int n = 0; n < 13; n++) ct_mem[n] = t2_ct[n];
        model_ks({104'h0, 24'h000018}, 3);
        run_id++;
        key_a = 24'h000018;
        pulse_en(0);
        repeat (600) @(negedge clk);
        total++;
        if (rdy_a !== 1'b0) begin
            bad++;
            $display("FAIL ksa_busy_rdy got=%b exp=0", rdy_a);
        end
        key_a = 24'h777777;
        en_a = 1'b1;
        repeat (5) @(negedge clk);
        en_a = 1'b0;
        wait_done(0, 4000, kok, rdys);
        total++;
        if (kok !== 1'b1) begin
            bad++;
            $display("FAIL ksa_en_key_ok got=%b exp=1", kok);
        end
        for (int n = 1; n < 13; n++) begin
            total++;
            if (pt_tag[n] != run_id || pt_mem[n] !== (ks[n] ^ t2_ct[n])) begin
                bad++;
                $display("FAIL ksa_en_pt[%0d] got=%h exp=%h", n, pt_mem[n], ks[n] ^ t2_ct[n]);
            end
        end
        dcnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done_a === 1'b1 || rdy_a !== 1'b1) dcnt++;
        end
        total++;
        if (dcnt != 0) begin
            bad++;
            $display("FAIL ksa_en_no_restart got=%0d exp=0", dcnt);
        end
    endtask

    task automatic test_rst_mid_prga;
        logic kok, rdys;
        bit hit;
        int w0, w1;
        for (int n = 0; n < 13; n++) ct_mem[n] = t2_ct[n];
        run_id++;
        w0 = wr_cnt;
        key_a = 24'h000018;
        pulse_en(0);
        hit = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (wr_cnt - w0 >= 3) begin
                hit = 1'b1;
                break;
            end
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL rst_prga_reach got=no_writes exp=3 writes");
        end
        rst = 1'b1;
        #1;
        total++;
        if (pt_wren_a !== 1'b0) begin
            bad++;
            $display("FAIL rst_prga_wren got=%b exp=0", pt_wren_a);
        end
        total++;
        if ({rdy_a, done_a, key_ok_a, ct_addr_a, pt_addr_a, pt_wrdata_a} !== 27'h0) begin
            bad++;
            $display("FAIL rst_prga_outputs got=%h exp=0",
                     {rdy_a, done_a, key_ok_a, ct_addr_a, pt_addr_a, pt_wrdata_a});
        end
        w1 = wr_cnt;
        repeat (3) @(negedge clk);
        total++;
        if (wr_cnt != w1) begin
            bad++;
            $display("FAIL rst_prga_writes got=%0d exp=0", wr_cnt - w1);
        end
        rst = 1'b0;
        @(negedge clk);
        model_ks({104'h0, 24'h000018}, 3);
        run_id++;
        w0 = wr_cnt;
        pulse_en(0);
        wait_done(0, 4000, kok, rdys);
        total++;
        if (kok !== 1'b1 || wr_cnt - w0 != 13) begin
            bad++;
            $display("FAIL rst_rerun_result got=kok%b/wr%0d exp=kok1/wr13", kok, wr_cnt - w0);
        end
        for (int n = 1; n < 13; n++) begin
            total++;
            if (pt_tag[n] != run_id || pt_mem[n] !== (ks[n] ^ t2_ct[n])) begin
                bad++;
                $display("FAIL rst_rerun_pt[%0d] got=%h exp=%h", n, pt_mem[n], ks[n] ^ t2_ct[n]);
            end
        end
    endtask

    task automatic test_back_to_back;
        logic kok, rdys;
        int w0;
        for (int n = 0; n < 13; n++) ct_mem[n] = t2_ct[n];
        model_ks({104'h0, 24'h000018}, 3);
        run_id++;
        @(negedge clk);
        key_a = 24'h000018;
        en_a  = 1'b1;
        wait_done(0, 4000, kok, rdys);
        for (int n = 1; n < 13; n++) begin
            total++;
            if (pt_tag[n] != run_id || pt_mem[n] !== (ks[n] ^ t2_ct[n])) begin
                bad++;
                $display("FAIL b2b_run1_pt[%0d] got=%h exp=%h", n, pt_mem[n], ks[n] ^ t2_ct[n]);
            end
        end
        key_a = 24'ha5c301;
        run_id++;
        w0 = wr_cnt;
        @(negedge clk);
        total++;
        if (rdy_a !== 1'b0) begin
            bad++;
            $display("FAIL b2b_accept_on_done got=rdy%b exp=rdy0", rdy_a);
        end
        en_a = 1'b0;
        model_ks({104'h0, 24'ha5c301}, 3);
        wait_done(0, 4000, kok, rdys);
        total++;
        if (kok !== 1'b1 || wr_cnt - w0 != 13) begin
            bad++;
            $display("FAIL b2b_run2_result got=kok%b/wr%0d exp=kok1/wr13", kok, wr_cnt - w0);
        end
        for (int n = 1; n < 13; n++) begin
            total++;
            if (pt_tag[n] != run_id || pt_mem[n] !== (ks[n] ^ t2_ct[n])) begin
                bad++;
                $display("FAIL b2b_run2_pt[%0d] got=%h exp=%h", n, pt_mem[n], ks[n] ^ t2_ct[n]);
            end
        end
    endtask

    initial begin
        for (int n = 0; n < 256; n++) begin
            ct_mem[n] = 8'h00;
            pt_tag[n] = 0;
        end
        test_reset();
        test_basic();
        test_key5();
        test_printable_abort();
        test_len_zero();
        test_en_mid_ksa();
        test_rst_mid_prga();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
